// File: rtl/instruction_memory_ctrl.sv
// Instruction memory with a valid/ready program loader and 1-cycle registered fetch.
// Optional macro IMEM_PARITY_EN adds a stored even-parity bit per word, checked on fetch.
module instruction_memory_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              mem_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              misalign,
  output logic              out_of_range,
  output logic              parity_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              misalign_q, misalign_d;
  logic              oor_q, oor_d;
  logic              parity_err_q, parity_err_d;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  fetch_idx;
  logic [DATA_W-1:0] rd_word;
  logic              addr_misalign;
  logic              addr_oor;
  logic              parity_bad;

  assign fetch_idx     = fetch_addr[IDX_W+1:2];
  assign rd_word       = mem[fetch_idx];
  assign addr_misalign = |fetch_addr[1:0];
  // Any upper address bit set is out of range, so high addresses never alias onto low words.
  assign addr_oor      = ((fetch_addr >> (IDX_W + 2)) != '0) || ({1'b0, fetch_idx} >= count_q);

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[wr_ptr_q] <= ^load_data;
    end
  end

  assign parity_bad = (^rd_word) != par_mem[fetch_idx];
`else
  assign parity_bad = 1'b0;
`endif

  // Storage has no reset; words past count_q are never readable, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    misalign_d    = 1'b0;
    oor_d         = 1'b0;
    parity_err_d  = 1'b0;
    mem_we        = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (reload) begin
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (load_last || (&wr_ptr_q)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (fetch_req) begin
          instr_valid_d = 1'b1;
          // Only the highest-priority fault is reported.
          if (addr_misalign) begin
            misalign_d = 1'b1;
            instr_d    = NOP_WORD;
          end else if (addr_oor) begin
            oor_d   = 1'b1;
            instr_d = NOP_WORD;
          end else if (parity_bad) begin
            parity_err_d = 1'b1;
            instr_d      = NOP_WORD;
          end else begin
            instr_d = rd_word;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      oor_q         <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      oor_q         <= oor_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign load_ready   = (state_q == ST_LOAD);
  assign mem_ready    = (state_q == ST_RUN);
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign misalign     = misalign_q;
  assign out_of_range = oor_q;
  assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Directed self-checking bench for instruction_memory_ctrl (default DEPTH=128, NOP_WORD=0).
// With IMEM_PARITY_EN defined, a stored bit is flipped to exercise the parity flag.
module tb_instruction_memory_ctrl;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic        mem_ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign;
  logic        out_of_range;
  logic        parity_err;

  int total = 0;
  int bad   = 0;

  instruction_memory_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .mem_ready   (mem_ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misalign    (misalign),
    .out_of_range(out_of_range),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 ns after the edge that consumed them.
  task automatic applyStimulus(input logic lv, input logic [31:0] ld, input logic ll,
                               input logic rl, input logic fr, input logic [31:0] fa);
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    reload     = rl;
    fetch_req  = fr;
    fetch_addr = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] exp_instr,
                            input logic exp_mis, input logic exp_oor, input logic exp_par);
    checkOutput({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({tag, ".instr"}, instr, exp_instr);
    checkOutput({tag, ".misalign"}, {31'b0, misalign}, {31'b0, exp_mis});
    checkOutput({tag, ".oor"}, {31'b0, out_of_range}, {31'b0, exp_oor});
    checkOutput({tag, ".parity"}, {31'b0, parity_err}, {31'b0, exp_par});
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reload     = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("por.load_ready", {31'b0, load_ready}, 32'd1);
    checkOutput("por.mem_ready", {31'b0, mem_ready}, 32'd0);
    checkOutput("por.instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("por.instr", instr, 32'h0);
    reset = 1'b1;

    // Reset in the middle of a load stream.
    applyStimulus(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'hDEAD_0002, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("rst1.load_ready", {31'b0, load_ready}, 32'd1);
    checkOutput("rst1.mem_ready", {31'b0, mem_ready}, 32'd0);
    checkOutput("rst1.instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst1.instr", instr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Load four words; the stream restarts at index 0 after reset.
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("load.ready_before_last", {31'b0, load_ready}, 32'd1);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("load.mem_ready", {31'b0, mem_ready}, 32'd1);
    checkOutput("load.load_ready", {31'b0, load_ready}, 32'd0);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkFetch("f0", 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4);
    checkFetch("f4", 32'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8);
    checkFetch("f8", 32'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC);
    checkFetch("fC", 32'h44, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle.valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("idle.instr_hold", instr, 32'h44);

    // Faulted fetches.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h6);
    checkFetch("f6_misalign", 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10);
    checkFetch("f10_unloaded", 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    checkFetch("f200_range", 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0202);
    checkFetch("f202_prio", 32'h0, 1'b1, 1'b0, 1'b0);

    // Reload with a same-cycle fetch; the fetch is dropped.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("reload.valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reload.load_ready", {31'b0, load_ready}, 32'd1);
    checkOutput("reload.mem_ready", {31'b0, mem_ready}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("loadfetch.valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'hBB, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("reload_drop.load_ready", {31'b0, load_ready}, 32'd1);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("reload1.mem_ready", {31'b0, mem_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkFetch("r_f0", 32'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4);
    checkFetch("r_f4", 32'h0, 1'b0, 1'b1, 1'b0);

    // Fill all 128 words without load_last.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      if (i == 127) begin
        checkOutput("fill.ready_at_127", {31'b0, load_ready}, 32'd1);
      end
      applyStimulus(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("fill.mem_ready", {31'b0, mem_ready}, 32'd1);
    checkOutput("fill.load_ready", {31'b0, load_ready}, 32'd0);
    applyStimulus(1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("extra.mem_ready", {31'b0, mem_ready}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1FC);
    checkFetch("fill_f1FC", 32'h107F, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkFetch("fill_f0", 32'h1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    checkFetch("fill_f200", 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkFetch("fill_alias", 32'h0, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_PARITY_EN
    dut.mem[1][0] = ~dut.mem[1][0];
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4);
    checkFetch("parity_f4", 32'h0, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4);
    checkFetch("noparity_f4", 32'h1001, 1'b0, 1'b0, 1'b0);
`endif

    // Reset while a fetch is pending.
    load_valid = 1'b0;
    reload     = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst2.valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst2.instr", instr, 32'h0);
    checkOutput("rst2.load_ready", {31'b0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst2.held_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8);
    checkOutput("rst2.load_fetch", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst2.mem_ready", {31'b0, mem_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
